alu_iter: RTL and testbench



---
 rtl/alu_pkg.sv | 25 ++
 rtl/alu_shift_step.sv | 24 ++
 rtl/alu_iter.sv | 131 +++++++++++++
 tb/tb_alu_iter.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes (also used by the ALU decoder),
// default width and the execute-stage state encoding.
package alu_pkg;

  localparam int XLEN_DEFAULT = 32;

  typedef enum logic [3:0] {
    ALU_AND     = 4'b0000,
    ALU_OR      = 4'b0001,
    ALU_ADD     = 4'b0010,
    ALU_SLL     = 4'b0011,
    ALU_SRL     = 4'b0100,
    ALU_SRA     = 4'b0101,
    ALU_SUB     = 4'b0110,
    ALU_SLT     = 4'b0111,
    ALU_ILLEGAL = 4'b1111
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_RESP  = 2'd2
  } alu_state_e;

endpackage

// File: rtl/alu_shift_step.sv
// Combinational single-bit shift of the working register, selected by
// operation; non-shift codes pass the data through unchanged.
module alu_shift_step
  import alu_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  alu_op_e          i_op,
  input  logic [XLEN-1:0]  i_data,
  output logic [XLEN-1:0]  o_data
);

  always_comb begin
    // NOTE: default assignment first so every path drives o_data (no latch).
    o_data = i_data;
    case (i_op)
      ALU_SLL: o_data = {i_data[XLEN-2:0], 1'b0};
      ALU_SRL: o_data = {1'b0, i_data[XLEN-1:1]};
      ALU_SRA: o_data = {i_data[XLEN-1], i_data[XLEN-1:1]};
      default: o_data = i_data;
    endcase
  end

endmodule

// File: rtl/alu_iter.sv
// Execute-stage ALU with valid/ready handshakes and iterative shifts.
// Define ALU_ITER_FAST_SHIFT_EN for a single-cycle barrel shifter instead.
module alu_iter
  import alu_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_control,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal
);

  localparam int SW = $clog2(XLEN);
  localparam logic [SW-1:0] CNT_ONE = SW'(1);

  alu_state_e      r_state, w_next_state;
  logic [XLEN-1:0] r_result;
  logic            r_zero, r_illegal;
  logic [XLEN-1:0] w_res;
  logic            w_illegal, w_go_shift, w_accept, w_last_shift;
  logic [SW-1:0]   w_shamt;

  assign w_accept = in_valid && (r_state == ST_IDLE);
  assign w_shamt  = operand_b[SW-1:0];

  always_comb begin
    w_res      = '0;
    w_illegal  = 1'b0;
    case (alu_control)
      ALU_AND: w_res = operand_a & operand_b;
      ALU_OR:  w_res = operand_a | operand_b;
      ALU_ADD: w_res = operand_a + operand_b;
      ALU_SUB: w_res = operand_a - operand_b;
      ALU_SLT: w_res = {{(XLEN-1){1'b0}}, $signed(operand_a) < $signed(operand_b)};
`ifdef ALU_ITER_FAST_SHIFT_EN
      ALU_SLL: w_res = operand_a << w_shamt;
      ALU_SRL: w_res = operand_a >> w_shamt;
      ALU_SRA: w_res = $unsigned($signed(operand_a) >>> w_shamt);
`else
      // Only reaches the result register when shamt is zero.
      ALU_SLL, ALU_SRL, ALU_SRA: w_res = operand_a;
`endif
      default: w_illegal = 1'b1;
    endcase
  end

`ifdef ALU_ITER_FAST_SHIFT_EN
  assign w_go_shift   = 1'b0;
  assign w_last_shift = 1'b0;
`else
  alu_op_e         r_op;
  logic [XLEN-1:0] r_work, w_step;
  logic [SW-1:0]   r_cnt;

  assign w_go_shift = ((alu_control == ALU_SLL) || (alu_control == ALU_SRL) ||
                       (alu_control == ALU_SRA)) && (w_shamt != '0);
  assign w_last_shift = (r_state == ST_SHIFT) && (r_cnt == CNT_ONE);

  alu_shift_step #(.XLEN(XLEN)) u_step (
    .i_op   (r_op),
    .i_data (r_work),
    .o_data (w_step)
  );

  // NOTE: working registers carry no reset; the state machine never reads them
  // before an accept loads them.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_op   <= alu_op_e'(alu_control);
      r_work <= operand_a;
      r_cnt  <= w_shamt;
    end else if (r_state == ST_SHIFT) begin
      r_work <= w_step;
      r_cnt  <= r_cnt - CNT_ONE;
    end
  end
`endif

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments for all sequential state.
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_result  <= '0;
      r_zero    <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_accept && !w_go_shift) begin
        r_result  <= w_res;
        r_zero    <= w_illegal || (w_res == '0);
        r_illegal <= w_illegal;
      end
`ifndef ALU_ITER_FAST_SHIFT_EN
      else if (w_last_shift) begin
        r_result  <= w_step;
        r_zero    <= (w_step == '0);
        r_illegal <= 1'b0;
      end
`endif
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept) w_next_state = w_go_shift ? ST_SHIFT : ST_RESP;
      ST_SHIFT: if (w_last_shift) w_next_state = ST_RESP;
      ST_RESP:  if (out_ready) w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == ST_IDLE);
    out_valid = (r_state == ST_RESP);
  end

  assign result  = r_result;
  assign zero    = r_zero;
  assign illegal = r_illegal;

endmodule

// File: tb/tb_alu_iter.sv
// Self-checking bench for alu_iter: directed vector table, hand-written
// stall/reset sequences and randomized requests against a reference model.
module tb_alu_iter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  alu_control = 4'b0;
  logic [31:0] operand_a = '0;
  logic [31:0] operand_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        zero;
  logic        illegal;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  alu_iter #(.XLEN(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .alu_control (alu_control),
    .operand_a   (operand_a),
    .operand_b   (operand_b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .zero        (zero),
    .illegal     (illegal)
  );

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        ill;
    logic        pulse;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference model: {illegal, result} straight from the operation table.
  function automatic logic [32:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
    int sh;
    sh = int'(b % 32);
    case (op)
      4'd0: return {1'b0, a & b};
      4'd1: return {1'b0, a | b};
      4'd2: return {1'b0, a + b};
      4'd6: return {1'b0, a - b};
      4'd7: return {1'b0, ($signed(a) < $signed(b)) ? 32'd1 : 32'd0};
      4'd3: return {1'b0, a << sh};
      4'd4: return {1'b0, a >> sh};
      4'd5: return {1'b0, 32'($signed(a) >>> sh)};
      default: return {1'b1, 32'd0};
    endcase
  endfunction

  function automatic int ref_lat(input logic [3:0] op, input logic [31:0] b);
`ifdef ALU_ITER_FAST_SHIFT_EN
    return 1;
`else
    if ((op == 4'd3 || op == 4'd4 || op == 4'd5) && (b % 32) != 0) return int'(b % 32) + 1;
    return 1;
`endif
  endfunction

  // Present one request, release inputs after accept, count cycles to out_valid.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic pulse, output int lat);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
    in_valid = 1'b1; alu_control = op; operand_a = a; operand_b = b;
    @(posedge clk); #1;
    in_valid = 1'b0; operand_a = $urandom; operand_b = $urandom; alu_control = 4'd2;
    lat = 1;
    while (!out_valid && lat < 200) begin
      if (pulse) in_valid = 1'($urandom_range(0, 1));
      check("in_ready_busy", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 1'b0;
  endtask

  task automatic take();
    check("hs_in_ready_low", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("post_hs_out_valid", 32'(out_valid), 32'd0);
    check("post_hs_in_ready", 32'(in_ready), 32'd1);
  endtask

  task automatic run_check(input string tag, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] eres, input logic eill,
                           input logic pulse);
    int lat;
    issue(op, a, b, pulse, lat);
    check({tag, "_lat"}, 32'(lat), 32'(ref_lat(op, b)));
    check({tag, "_res"}, result, eres);
    check({tag, "_zero"}, 32'(zero), 32'(eill || (eres == 32'd0)));
    check({tag, "_ill"}, 32'(illegal), 32'(eill));
    take();
  endtask

  vec_t vecs[12];

  initial begin
    logic [32:0] m;
    logic [3:0]  op;
    logic [31:0] a, b, hold_res;
    int          lat;

    vecs[0]  = '{4'b0010, 32'h7FFF_FFFF, 32'd1,        32'h8000_0000, 1'b0, 1'b0};
    vecs[1]  = '{4'b0110, 32'd5,         32'd5,        32'd0,         1'b0, 1'b0};
    vecs[2]  = '{4'b0111, 32'hFFFF_FFFF, 32'd1,        32'd1,         1'b0, 1'b0};
    vecs[3]  = '{4'b0101, 32'h8000_0000, 32'd31,       32'hFFFF_FFFF, 1'b0, 1'b1};
    vecs[4]  = '{4'b0011, 32'h1,         32'd0,        32'h1,         1'b0, 1'b0};
    vecs[5]  = '{4'b0100, 32'hF0,        32'd4,        32'hF,         1'b0, 1'b0};
    vecs[6]  = '{4'b0000, 32'hF0F0,      32'hFF00,     32'hF000,      1'b0, 1'b0};
    vecs[7]  = '{4'b0001, 32'h1234_0000, 32'h5678,     32'h1234_5678, 1'b0, 1'b0};
    vecs[8]  = '{4'b1111, 32'h1234,      32'h5678,     32'd0,         1'b1, 1'b0};
    vecs[9]  = '{4'b1000, 32'hFFFF,      32'h1,        32'd0,         1'b1, 1'b0};
    vecs[10] = '{4'b0111, 32'd1,         32'hFFFF_FFFF, 32'd0,        1'b0, 1'b0};
    vecs[11] = '{4'b0110, 32'd0,         32'd1,        32'hFFFF_FFFF, 1'b0, 1'b0};

    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_zero", 32'(zero), 32'd0);
    check("rst_illegal", 32'(illegal), 32'd0);

    foreach (vecs[i])
      run_check($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                vecs[i].res, vecs[i].ill, vecs[i].pulse);

    // Illegal code with the consumer stalled: outputs hold, nothing new accepted.
    issue(4'b1111, 32'hAAAA, 32'h5555, 1'b0, lat);
    check("stall_lat", 32'(lat), 32'd1);
    hold_res = result;
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1; alu_control = 4'b0010; operand_a = 32'd7; operand_b = 32'd9;
      @(posedge clk); #1;
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_result", result, 32'd0);
      check("stall_illegal", 32'(illegal), 32'd1);
      check("stall_zero", 32'(zero), 32'd1);
      check("stall_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    check("stall_hold", result, hold_res);
    take();

    // Reset in the middle of a long shift discards it.
    @(negedge clk);
    in_valid = 1'b1; alu_control = 4'b0011; operand_a = 32'h1; operand_b = 32'd20;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_result", result, 32'd0);
    check("midrst_illegal", 32'(illegal), 32'd0);
    run_check("post_rst_and", 4'b0000, 32'hF0F0, 32'hFF00, 32'hF000, 1'b0, 1'b0);

    // Randomized requests, mixing legal codes and random (possibly illegal) ones.
    for (int n = 0; n < 150; n++) begin
      op = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'($urandom_range(0, 7));
      a  = $urandom;
      b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 2)) : $urandom;
      if (n % 7 == 0) b = a;
      m  = ref_alu(op, a, b);
      run_check($sformatf("rnd%0d_op%0h", n, op), op, a, b, m[31:0], m[32], 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
